// File: rtl/victim_evict_writer_pkg.sv
// Shared types and constants for the victim-cache eviction writer.
// Line geometry is fixed here so the FIFO, the interface and the top all agree on it.
package victim_pkg;

    localparam int TAG_W  = 44;
    localparam int LINE_W = 512;
    localparam int IDX_W  = 6;
    localparam int OFF_W  = 6;
    localparam int ADDR_W = IDX_W + OFF_W;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  idx;
        logic [LINE_W-1:0] data;
    } victim_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } drain_state_t;

    // Byte 0 of the line is bits 7:0.
    function automatic logic [7:0] line_byte(input logic [LINE_W-1:0] line,
                                             input logic [OFF_W-1:0]  off);
        return line[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/victim_evict_writer_if.sv
// Bundle of the L1 eviction port, victim cache write port and snoop lookup port.
// The slave modport is the writer's view; master is the surrounding logic.
interface victim_evict_writer_if #(
    parameter int DEPTH      = 4,
    parameter int VC_ENTRIES = 8
);
    import victim_pkg::*;

    localparam int WAY_W = $clog2(VC_ENTRIES);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              evict_valid;
    logic              evict_ready;
    logic [IDX_W-1:0]  evict_idx;
    logic [TAG_W-1:0]  evict_tag;
    logic [LINE_W-1:0] evict_data;

    logic              vc_busy;
    logic              vc_write_en;
    logic [ADDR_W-1:0] vc_addr;
    logic [TAG_W-1:0]  vc_tag;
    logic [LINE_W-1:0] vc_data;
    logic [WAY_W-1:0]  vc_way;

    logic              lookup_valid;
    logic [ADDR_W-1:0] lookup_addr;
    logic [TAG_W-1:0]  lookup_tag;
    logic              buf_hit;
    logic [7:0]        buf_byte;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  evict_valid, evict_idx, evict_tag, evict_data,
        input  vc_busy, lookup_valid, lookup_addr, lookup_tag,
        output evict_ready, vc_write_en, vc_addr, vc_tag, vc_data, vc_way,
        output buf_hit, buf_byte, count
    );

    modport master (
        output evict_valid, evict_idx, evict_tag, evict_data,
        output vc_busy, lookup_valid, lookup_addr, lookup_tag,
        input  evict_ready, vc_write_en, vc_addr, vc_tag, vc_data, vc_way,
        input  buf_hit, buf_byte, count
    );

endinterface

// File: rtl/victim_evict_writer_fifo.sv
// Eviction queue: wrap-bit pointers, occupancy, and every slot exposed with its
// valid bit so the snoop logic can search entries that have not been written yet.
module victim_fifo
    import victim_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  victim_entry_t         push_entry_i,
    input  logic                  pop_i,
    output victim_entry_t         head_o,
    output victim_entry_t         entries_o [DEPTH],
    output logic [DEPTH-1:0]      valid_o,
    output logic [$clog2(DEPTH)-1:0] rd_idx_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;
    logic [AW-1:0] rel;
    victim_entry_t mem_q [DEPTH];

    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign count_o  = wr_ptr_q - rd_ptr_q;
    assign rd_idx_o = rd_ptr_q[AW-1:0];
    assign head_o   = mem_q[rd_ptr_q[AW-1:0]];

    // A full queue refuses the push even when a pop frees a slot this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_comb begin
        valid_o = '0;
        rel     = '0;
        for (int s = 0; s < DEPTH; s++) begin
            rel        = AW'(s) - rd_ptr_q[AW-1:0];
            valid_o[s] = ({1'b0, rel} < count_o);
            entries_o[s] = mem_q[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_entry_i;
        end
    end

endmodule

// File: rtl/victim_evict_writer.sv
// Queues L1 evictions and drains them one per two cycles into the victim cache,
// while answering late snoop lookups for lines that are still in flight.
module victim_evict_writer
    import victim_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int VC_ENTRIES = 8
) (
    input logic                   clk,
    input logic                   reset,
    victim_evict_writer_if.slave  bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int WAY_W = $clog2(VC_ENTRIES);
    localparam logic [WAY_W-1:0] WAY_LAST = WAY_W'(VC_ENTRIES - 1);

    victim_entry_t     push_entry;
    victim_entry_t     head;
    victim_entry_t     entries [DEPTH];
    logic [DEPTH-1:0]  ent_vld;
    logic [AW-1:0]     rd_idx;
    logic              full, empty;
    logic [AW:0]       occupancy;
    logic              push, pop;

    drain_state_t      state_q;
    logic              vc_we_q;
    logic [ADDR_W-1:0] vc_addr_q;
    logic [TAG_W-1:0]  vc_tag_q;
    logic [LINE_W-1:0] vc_data_q;
    logic [WAY_W-1:0]  vc_way_q;

    logic              lk_vld_q;
    logic [ADDR_W-1:0] lk_addr_q;
    logic              snp_hit_d;
    logic [LINE_W-1:0] snp_line_d;
    logic [AW-1:0]     slot;
    logic              buf_hit_q;
    logic [7:0]        buf_byte_q;

    assign push_entry = '{tag: bus.evict_tag, idx: bus.evict_idx, data: bus.evict_data};
    assign push       = bus.evict_valid && !full;
    assign pop        = (state_q == IDLE) && !empty && !bus.vc_busy;

    victim_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push),
        .push_entry_i(push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .entries_o   (entries),
        .valid_o     (ent_vld),
        .rd_idx_o    (rd_idx),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (occupancy)
    );

    // Drain FSM: load in IDLE, strobe for exactly the ISSUE cycle, then advance the way.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            vc_we_q   <= 1'b0;
            vc_addr_q <= '0;
            vc_tag_q  <= '0;
            vc_data_q <= '0;
            vc_way_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q   <= ISSUE;
                        vc_we_q   <= 1'b1;
                        vc_addr_q <= {head.idx, {OFF_W{1'b0}}};
                        vc_tag_q  <= head.tag;
                        vc_data_q <= head.data;
                    end
                end
                ISSUE: begin
                    state_q  <= IDLE;
                    vc_we_q  <= 1'b0;
                    vc_way_q <= (vc_way_q == WAY_LAST) ? '0 : vc_way_q + 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    vc_we_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (bus.lookup_valid) begin
            lk_addr_q <= bus.lookup_addr;
        end
    end

    // Walk from the oldest slot to the newest so a later match overrides an earlier one;
    // the line being issued is older than anything still queued.
    always_comb begin
        snp_hit_d  = 1'b0;
        snp_line_d = '0;
        slot       = '0;
        if (lk_vld_q) begin
            if ((state_q == ISSUE) && (vc_tag_q == bus.lookup_tag) &&
                (vc_addr_q[ADDR_W-1:OFF_W] == lk_addr_q[ADDR_W-1:OFF_W])) begin
                snp_hit_d  = 1'b1;
                snp_line_d = vc_data_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
                slot = rd_idx + AW'(k);
                if (ent_vld[slot] && (entries[slot].tag == bus.lookup_tag) &&
                    (entries[slot].idx == lk_addr_q[ADDR_W-1:OFF_W])) begin
                    snp_hit_d  = 1'b1;
                    snp_line_d = entries[slot].data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lk_vld_q   <= 1'b0;
            buf_hit_q  <= 1'b0;
            buf_byte_q <= 8'h00;
        end else begin
            lk_vld_q   <= bus.lookup_valid;
            buf_hit_q  <= snp_hit_d;
            buf_byte_q <= snp_hit_d ? line_byte(snp_line_d, lk_addr_q[OFF_W-1:0]) : 8'h00;
        end
    end

    assign bus.evict_ready = !full;
    assign bus.vc_write_en = vc_we_q;
    assign bus.vc_addr     = vc_addr_q;
    assign bus.vc_tag      = vc_tag_q;
    assign bus.vc_data     = vc_data_q;
    assign bus.vc_way      = vc_way_q;
    assign bus.buf_hit     = buf_hit_q;
    assign bus.buf_byte    = buf_byte_q;
    assign bus.count       = occupancy;

endmodule
